// File: rtl/ysyx_23060077_lsu_pkg.sv
// Shared encodings for the load/store unit: memory ops, bus sizes, FSM states.
// The helpers classify an op so the top and future cache code agree.
package ysyx_23060077_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_opt_e;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  function automatic logic is_load(logic [3:0] o);
    return o inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(logic [3:0] o);
    return o inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic [2:0] opt_size(logic [3:0] o);
    case (o)
      MEM_LH, MEM_LHU, MEM_SH: return SIZE_H;
      MEM_LW, MEM_SW:          return SIZE_W;
      default:                 return SIZE_B;
    endcase
  endfunction

  function automatic logic misaligned(logic [3:0] o, logic [1:0] lo);
    logic [2:0] sz;
    sz = opt_size(o);
    return ((sz == SIZE_H) && lo[0]) || ((sz == SIZE_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060077_lsu_align.sv
// Combinational byte-lane steering: store data/strobes onto the bus word and
// load extraction with sign/zero extension from the lane-aligned read word.
module ysyx_23060077_lsu_align
  import ysyx_23060077_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]              opt,
  input  logic [1:0]              off,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   load_data
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] shifted;

  assign wdata   = store_data << {off, 3'b000};
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    wstrb = '0;
    case (opt)
      MEM_SB:  wstrb = NB'(1) << off;
      MEM_SH:  wstrb = NB'(3) << off;
      MEM_SW:  wstrb = '1;
      default: wstrb = '0;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (opt)
      MEM_LB:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      MEM_LH:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      MEM_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MEM_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      MEM_LW:  load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060077_lsu.sv
// Load/store stage: one op in flight, AXI4-Lite-subset master, registered
// result held in DONE until write-back takes it.
module ysyx_23060077_lsu
  import ysyx_23060077_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [DATA_WIDTH-1:0]   ex_alu_out,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  input  logic [3:0]              ex_mem_opt,
  input  logic [RD_WIDTH-1:0]     ex_rd,
  input  logic                    ex_rd_wen,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arsize,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awsize,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic [RD_WIDTH-1:0]     wb_rd,
  output logic                    wb_rd_wen,
  output logic                    wb_err
);
  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, sdata_q, sdata_d;
  logic [3:0]            opt_q, opt_d;
  logic [RD_WIDTH-1:0]   rd_q, rd_d;
  logic                  rd_wen_q, rd_wen_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  wb_err_q, wb_err_d, wb_rd_wen_q, wb_rd_wen_d;
  logic [DATA_WIDTH-1:0] load_data;

  ysyx_23060077_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .opt        (opt_q),
    .off        (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (rdata),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .load_data  (load_data)
  );

  // Bus fields come straight from latched state so they stay stable while valid.
  assign ex_ready  = (state_q == S_IDLE);
  assign arvalid   = (state_q == S_AR);
  assign rready    = (state_q == S_R);
  assign awvalid   = (state_q == S_AW_W) && !aw_done_q;
  assign wvalid    = (state_q == S_AW_W) && !w_done_q;
  assign bready    = (state_q == S_B);
  assign wb_valid  = (state_q == S_DONE);
  assign araddr    = ADDR_WIDTH'(addr_q);
  assign awaddr    = ADDR_WIDTH'(addr_q);
  assign arsize    = opt_size(opt_q);
  assign awsize    = opt_size(opt_q);
  assign wb_data   = wb_data_q;
  assign wb_rd     = rd_q;
  assign wb_rd_wen = wb_rd_wen_q;
  assign wb_err    = wb_err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    opt_d       = opt_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;
    wb_rd_wen_d = wb_rd_wen_q;
    case (state_q)
      S_IDLE: if (ex_valid) begin
        addr_d      = ex_alu_out;
        sdata_d     = ex_store_data;
        opt_d       = ex_mem_opt;
        rd_d        = ex_rd;
        rd_wen_d    = ex_rd_wen;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        wb_data_d   = '0;
        wb_err_d    = 1'b0;
        wb_rd_wen_d = 1'b0;
        if (misaligned(ex_mem_opt, ex_alu_out[1:0])) begin
          wb_err_d = 1'b1;
          state_d  = S_DONE;
        end else if (is_load(ex_mem_opt)) begin
          state_d = S_AR;
        end else if (is_store(ex_mem_opt)) begin
          state_d = S_AW_W;
        end else begin
          wb_data_d   = ex_alu_out;
          wb_rd_wen_d = ex_rd_wen;
          state_d     = S_DONE;
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R: if (rvalid) begin
        wb_err_d    = (rresp != 2'b00);
        wb_data_d   = (rresp == 2'b00) ? load_data : '0;
        wb_rd_wen_d = rd_wen_q && (rresp == 2'b00);
        state_d     = S_DONE;
      end
      S_AW_W: begin
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: if (bvalid) begin
        wb_err_d = (bresp != 2'b00);
        state_d  = S_DONE;
      end
      S_DONE: if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      sdata_q     <= '0;
      opt_q       <= MEM_NONE;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      wb_rd_wen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      opt_q       <= opt_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
      wb_rd_wen_q <= wb_rd_wen_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Bench for the LSU: directed vector table, random ops against a byte-level
// reference model, and a reset-during-read sequence. Acts as the bus slave.
module tb_ysyx_23060077_lsu;
  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic clock = 1'b0, rst_n = 1'b0;
  logic ex_valid = 0, ex_ready, ex_rd_wen = 0;
  logic [31:0] ex_alu_out = 0, ex_store_data = 0;
  logic [3:0] ex_mem_opt = 0;
  logic [4:0] ex_rd = 0, wb_rd;
  logic arvalid, arready = 0, rvalid = 0, rready, awvalid, awready = 0;
  logic wvalid, wready = 0, bvalid = 0, bready, wb_valid, wb_ready = 0, wb_rd_wen, wb_err;
  logic [31:0] araddr, awaddr, rdata = 0, wdata, wb_data;
  logic [2:0] arsize, awsize;
  logic [1:0] rresp = 0, bresp = 0;
  logic [3:0] wstrb;

  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  ysyx_23060077_lsu dut (
    .clock(clock), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_mem_opt(ex_mem_opt),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arsize(arsize), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid),
    .bready(bready), .bresp(bresp), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen), .wb_err(wb_err)
  );

  typedef struct {
    logic [3:0] op; logic [31:0] addr, sdata, rdata; logic [1:0] resp;
    logic [4:0] rd; logic rd_wen; int ar_lat, r_lat, aw_lat, w_lat, b_lat, wb_hold;
  } op_t;

  typedef struct {
    logic [31:0] data; logic err, rdwen, ar, aw; logic [2:0] size;
    logic [31:0] baddr, wdata; logic [3:0] wstrb; logic [4:0] rd;
    int lat, wbeats, viol;
  } res_t;

  typedef struct {
    string name; op_t o; logic [31:0] e_data; logic e_err, e_rdwen, e_ar, e_aw;
    logic [2:0] e_size; logic [31:0] e_wdata; logic [3:0] e_wstrb; int e_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic op_t mk(logic [3:0] op, logic [31:0] addr, logic [31:0] sdata,
                             logic [31:0] rd_word, logic [1:0] resp, int arl, int rl,
                             int awl, int wl, int bl, int hold);
    op_t o;
    o.op = op; o.addr = addr; o.sdata = sdata; o.rdata = rd_word; o.resp = resp;
    o.rd = 5'(1 + ($urandom % 31)); o.rd_wen = 1'b1;
    o.ar_lat = arl; o.r_lat = rl; o.aw_lat = awl; o.w_lat = wl; o.b_lat = bl; o.wb_hold = hold;
    return o;
  endfunction

  // Reference: byte arithmetic on the op description, independent of lane logic.
  function automatic res_t model(op_t o);
    res_t e;
    int off, nbytes;
    longint v, full;
    logic ld, st, sgn, mis;
    e = '{default: 0};
    off = int'(o.addr % 4);
    ld  = (o.op >= LB) && (o.op <= LHU);
    st  = (o.op >= SB) && (o.op <= SW);
    sgn = (o.op == LB) || (o.op == LH);
    nbytes = (o.op == LB || o.op == LBU || o.op == SB) ? 1 :
             (o.op == LH || o.op == LHU || o.op == SH) ? 2 : 4;
    mis = (ld || st) && ((nbytes == 2 && off % 2 != 0) || (nbytes == 4 && off != 0));
    e.rd = o.rd;
    e.size = (nbytes == 1) ? 3'd0 : (nbytes == 2) ? 3'd1 : 3'd2;
    if (mis) begin
      e.err = 1;
    end else if (ld) begin
      e.ar = 1; e.baddr = o.addr;
      full = longint'(1) << (8 * nbytes);
      v = (longint'(o.rdata) >> (8 * off)) % full;
      if (sgn && v >= full / 2) v = v - full;
      e.err = (o.resp != 0);
      e.data = e.err ? 32'd0 : 32'(v);
      e.rdwen = o.rd_wen && !e.err;
    end else if (st) begin
      e.aw = 1; e.baddr = o.addr; e.wbeats = 1;
      e.wdata = 32'(longint'(o.sdata) * (longint'(1) << (8 * off)));
      e.wstrb = 4'(((1 << nbytes) - 1) << off);
      e.err = (o.resp != 0);
    end else begin
      e.data = o.addr; e.rdwen = o.rd_wen;
    end
    return e;
  endfunction

  // Issues one op and plays the bus slave; counts protocol violations.
  task automatic run_op(input op_t o, output res_t r);
    int cyc, arc, rc, awc, wc, bc;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, fa, fr, faw, fw, fb;
    logic pend_ar, pend_aw, pend_w;
    logic [31:0] pa, paw, pw; logic [3:0] ps;
    r = '{default: 0};
    {arc, rc, awc, wc, bc} = '0;
    {ar_hs, r_hs, aw_hs, w_hs, b_hs, pend_ar, pend_aw, pend_w} = '0;
    {pa, paw, pw, ps} = '0;
    @(negedge clock);
    ex_valid = 1; ex_mem_opt = o.op; ex_alu_out = o.addr; ex_store_data = o.sdata;
    ex_rd = o.rd; ex_rd_wen = o.rd_wen;
    if (!ex_ready) r.viol++;
    @(posedge clock); #1;
    ex_valid = 0; ex_alu_out = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);
    cyc = 0;
    while (1) begin
      cyc++;
      if (wb_valid) break;
      if (cyc > 200) begin r.viol++; $display("FAIL timeout: op %0d stuck", o.op); break; end
      if (ex_ready) r.viol++;
      if (pend_ar && (!arvalid || araddr !== pa)) r.viol++;
      if (pend_aw && (!awvalid || awaddr !== paw)) r.viol++;
      if (pend_w && (!wvalid || wdata !== pw || wstrb !== ps)) r.viol++;
      if (bready && !(aw_hs && w_hs)) r.viol++;
      if (arvalid) begin r.ar = 1; r.size = arsize; r.baddr = araddr; end
      if (awvalid) begin r.aw = 1; r.size = awsize; r.baddr = awaddr; end
      if (wvalid) begin r.wdata = wdata; r.wstrb = wstrb; end
      arready = arvalid && arc >= o.ar_lat; if (arvalid) arc++;
      rvalid  = ar_hs && !r_hs && rc >= o.r_lat; if (ar_hs && !r_hs) rc++;
      rdata = o.rdata; rresp = o.resp; bresp = o.resp;
      awready = awvalid && awc >= o.aw_lat; if (awvalid) awc++;
      wready  = wvalid && wc >= o.w_lat; if (wvalid) wc++;
      bvalid  = aw_hs && w_hs && !b_hs && bc >= o.b_lat; if (aw_hs && w_hs && !b_hs) bc++;
      fa = arvalid && arready; fr = rvalid && rready; faw = awvalid && awready;
      fw = wvalid && wready; fb = bvalid && bready;
      if (fw) r.wbeats++;
      pend_ar = arvalid && !fa; pa = araddr;
      pend_aw = awvalid && !faw; paw = awaddr;
      pend_w = wvalid && !fw; pw = wdata; ps = wstrb;
      @(posedge clock); #1;
      ar_hs |= fa; r_hs |= fr; aw_hs |= faw; w_hs |= fw; b_hs |= fb;
    end
    {arready, rvalid, awready, wready, bvalid} = '0;
    r.lat = cyc;
    r.data = wb_data; r.err = wb_err; r.rdwen = wb_rd_wen; r.rd = wb_rd;
    for (int h = 0; h < o.wb_hold; h++) begin
      @(posedge clock); #1;
      if (!wb_valid || wb_data !== r.data || wb_err !== r.err || wb_rd_wen !== r.rdwen ||
          wb_rd !== r.rd || ex_ready || arvalid || awvalid) r.viol++;
    end
    wb_ready = 1;
    @(posedge clock); #1;
    wb_ready = 0;
    if (!ex_ready || wb_valid) r.viol++;
  endtask

  task automatic check_vs_model(input string tag, input op_t o, input res_t r);
    res_t e;
    e = model(o);
    chk({tag, ".data"}, r.data, e.data);
    chk({tag, ".err"}, 32'(r.err), 32'(e.err));
    chk({tag, ".rdwen"}, 32'(r.rdwen), 32'(e.rdwen));
    chk({tag, ".rd"}, 32'(r.rd), 32'(e.rd));
    chk({tag, ".bus"}, {30'd0, r.ar, r.aw}, {30'd0, e.ar, e.aw});
    chk({tag, ".proto"}, 32'(r.viol), 0);
    if (e.ar || e.aw) begin
      chk({tag, ".size"}, 32'(r.size), 32'(e.size));
      chk({tag, ".baddr"}, r.baddr, e.baddr);
    end
    if (e.aw) begin
      chk({tag, ".wdata"}, r.wdata, e.wdata);
      chk({tag, ".wstrb"}, 32'(r.wstrb), 32'(e.wstrb));
      chk({tag, ".wbeats"}, 32'(r.wbeats), 1);
    end
  endtask

  vec_t tbl[10];
  res_t r;
  op_t o;

  initial begin
    // name, op, data, err, rdwen, ar, aw, size, wdata, wstrb, exact latency (0 = n/a)
    tbl[0] = '{"none",  mk(NONE, 32'h1234_5678, 0, 0, 0, 0,0,0,0,0,0), 32'h1234_5678, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{"lb",    mk(LB,  32'h8000_0003, 0, 32'h80AA_BBCC, 0, 0,0,0,0,0,0), 32'hFFFF_FF80, 0, 1, 1, 0, 0, 0, 0, 3};
    tbl[2] = '{"lbu",   mk(LBU, 32'h8000_0003, 0, 32'h80AA_BBCC, 0, 1,2,0,0,0,0), 32'h0000_0080, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{"sh",    mk(SH,  32'h8000_0002, 32'h0000_BEEF, 0, 0, 0,0,3,0,1,0), 32'h0, 0, 0, 0, 1, 1, 32'hBEEF_0000, 4'b1100, 0};
    tbl[4] = '{"lwmis", mk(LW,  32'h8000_0001, 0, 32'hDEAD_BEEF, 0, 0,0,0,0,0,0), 32'h0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{"lwerr", mk(LW,  32'h8000_0004, 0, 32'hCAFE_F00D, 2'b10, 0,1,0,0,0,4), 32'h0, 1, 0, 1, 0, 2, 0, 0, 0};
    tbl[6] = '{"lh",    mk(LH,  32'h8000_0002, 0, 32'h8001_1234, 0, 0,0,0,0,0,1), 32'hFFFF_8001, 0, 1, 1, 0, 1, 0, 0, 0};
    tbl[7] = '{"sw",    mk(SW,  32'h8000_0000, 32'hDEAD_BEEF, 0, 0, 0,0,0,2,0,0), 32'h0, 0, 0, 0, 1, 2, 32'hDEAD_BEEF, 4'b1111, 0};
    tbl[8] = '{"sb",    mk(SB,  32'h8000_0001, 32'h0000_00A5, 0, 0, 1,0,1,1,0,0), 32'h0, 0, 0, 0, 1, 0, 32'h0000_A500, 4'b0010, 0};
    tbl[9] = '{"lhu",   mk(LHU, 32'h8000_0000, 0, 32'h1234_F00D, 0, 0,0,0,0,0,0), 32'h0000_F00D, 0, 1, 1, 0, 1, 0, 0, 0};

    repeat (3) @(posedge clock);
    #1;
    chk("rst.valids", {24'd0, ex_ready, arvalid, rready, awvalid, wvalid, bready, wb_valid, 1'b0}, 32'h80);
    chk("rst.data", wb_data | araddr | awaddr | wdata | {28'd0, wstrb}, 0);
    chk("rst.misc", {24'd0, wb_rd, wb_rd_wen, wb_err, 1'b0}, 0);
    @(negedge clock); rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].o, r);
      chk({tbl[i].name, ".tdata"}, r.data, tbl[i].e_data);
      chk({tbl[i].name, ".terr"}, 32'(r.err), 32'(tbl[i].e_err));
      chk({tbl[i].name, ".trdwen"}, 32'(r.rdwen), 32'(tbl[i].e_rdwen));
      chk({tbl[i].name, ".tbus"}, {30'd0, r.ar, r.aw}, {30'd0, tbl[i].e_ar, tbl[i].e_aw});
      chk({tbl[i].name, ".tproto"}, 32'(r.viol), 0);
      if (tbl[i].e_ar || tbl[i].e_aw) chk({tbl[i].name, ".tsize"}, 32'(r.size), 32'(tbl[i].e_size));
      if (tbl[i].e_aw) begin
        chk({tbl[i].name, ".twdata"}, r.wdata, tbl[i].e_wdata);
        chk({tbl[i].name, ".twstrb"}, 32'(r.wstrb), 32'(tbl[i].e_wstrb));
      end
      if (tbl[i].e_lat != 0) chk({tbl[i].name, ".tlat"}, 32'(r.lat), 32'(tbl[i].e_lat));
      if (tbl[i].e_ar) chk({tbl[i].name, ".tlatmin"}, 32'(r.lat >= 3), 1);
      chk({tbl[i].name, ".trd"}, 32'(r.rd), 32'(tbl[i].o.rd));
    end

    // Reset while the read data phase is pending.
    @(negedge clock);
    ex_valid = 1; ex_mem_opt = LW; ex_alu_out = 32'h8000_0010; ex_rd = 5'd3; ex_rd_wen = 1;
    @(posedge clock); #1; ex_valid = 0; arready = 1;
    @(posedge clock); #1; arready = 0;
    chk("rstR.inR", {31'd0, rready}, 1);
    #2 rst_n = 0;
    #1;
    chk("rstR.valids", {26'd0, rready, arvalid, awvalid, wvalid, bready, wb_valid}, 0);
    chk("rstR.data", wb_data | araddr | {27'd0, wb_rd, 1'b0} | {31'd0, wb_err}, 0);
    @(negedge clock); rst_n = 1;
    #1;
    chk("rstR.exready", {31'd0, ex_ready}, 1);
    o = mk(LW, 32'h8000_0020, 0, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 0, 0);
    run_op(o, r);
    check_vs_model("post_rst", o, r);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 8));
      o = mk(op, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
      o.rd_wen = 1'($urandom);
      run_op(o, r);
      check_vs_model($sformatf("rnd%0d", k), o, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_lsu.md
Name: ysyx_23060077_lsu

Overview:
Load/store stage directly downstream of the EX ALU. Consumes the ALU result (effective address for loads/stores, pass-through value otherwise) plus store data. Performs the memory access over an AXI4-Lite-subset master port, then hands the aligned, sign/zero-extended result to write-back via a valid/ready handshake. One operation is in flight at a time.

Parameters:
DATA_WIDTH, 32, data/ALU result width
ADDR_WIDTH, 32, bus address width
RD_WIDTH, 5, destination register index width

Ports:
clock  in  1  stage clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX has an operation
ex_ready  out  1  LSU accepts an operation
ex_alu_out  in  DATA_WIDTH  ALU result / effective address
ex_store_data  in  DATA_WIDTH  rs2 value for stores
ex_mem_opt  in  4  NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
ex_rd  in  RD_WIDTH  destination register
ex_rd_wen  in  1  write-back enable
arvalid/arready  out/in  1  read address handshake
araddr  out  ADDR_WIDTH  read byte address
arsize  out  3  0=byte, 1=half, 2=word
rvalid/rready  in/out  1  read data handshake
rdata  in  DATA_WIDTH  lane-aligned read word
rresp  in  2  read response
awvalid/awready  out/in  1  write address handshake
awaddr  out  ADDR_WIDTH  write byte address
awsize  out  3  as arsize
wvalid/wready  out/in  1  write data handshake
wdata  out  DATA_WIDTH  lane-shifted store data
wstrb  out  DATA_WIDTH/8  byte strobes
bvalid/bready  in/out  1  write response handshake
bresp  in  2  write response
wb_valid  out  1  result ready for WB
wb_ready  in  1  WB accepts
wb_data  out  DATA_WIDTH  result
wb_rd  out  RD_WIDTH  latched ex_rd
wb_rd_wen  out  1  latched ex_rd_wen, forced 0 for stores and errors
wb_err  out  1  misaligned access or non-OKAY response

Behaviour:
- Reset: state IDLE. All valid outputs and rready/bready are 0. All data, address, strobe, rd and err outputs are 0.
- ex_ready = (state==IDLE). Accept on ex_valid&&ex_ready. Latch address, store data, opt, rd and rd_wen.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Go to DONE, wb_err=1, wb_rd_wen=0, no bus transaction.
- States:
  - IDLE -> DONE for NONE; -> AR for loads; -> AW_W for stores; -> DONE for misaligned ops.
  - AR: arvalid=1 until arready, then -> R.
  - R: rready=1; on rvalid -> DONE.
  - AW_W: awvalid and wvalid are asserted independently. Each drops after its own handshake, tracked by aw_done/w_done flags. When both handshakes are done (same cycle allowed) -> B.
  - B: bready=1; on bvalid -> DONE.
  - DONE: wb_valid=1, outputs held stable; on wb_ready -> IDLE.
- The handshake is a fixed sequence, so there is no accept in the same cycle as wb_ready. Minimum latency is 1 cycle for NONE (accept -> wb_valid next cycle); loads take ≥3 cycles.
- VALID signals never drop before their handshake completes. araddr/awaddr/wdata/wstrb stay stable while valid.
- Store lanes: wdata = store_data << (8*addr[1:0]).
  - SB: wstrb = 0001 << addr[1:0]
  - SH: wstrb = 0011 << addr[1:0]
  - SW: wstrb = 1111
- Load extraction: shifted = rdata >> (8*addr[1:0]).
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: as-is.
- NONE: wb_data = latched ex_alu_out. Stores: wb_data = 0.
- rresp/bresp != 0 sets wb_err=1 and forces wb_rd_wen=0. wb_data for a failed load is 0.
- Reset mid-transaction: all state clears immediately and asynchronously. The bus slave is reset by the same rst_n.

Decomposition:
- Shared define file holds:
  - MEM_OPT encodings (NONE=0, LB, LH, LW, LBU, LHU, SB, SH, SW)
  - size encodings
  - FSM state encodings (IDLE, AR, R, AW_W, B, DONE)
- One natural sub-module, ysyx_23060077_lsu_align: purely combinational store lane/strobe generation and load extract/extend, shared with future cache code.

Test Plan:
- NONE, alu_out=0x1234_5678, wb_ready=1 -> wb_valid one cycle after accept, wb_data=0x12345678, no ar/aw activity.
- LB addr=0x8000_0003, rdata=0x80AA_BBCC -> araddr=0x80000003, arsize=0, wb_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr=0x8000_0002, store_data=0x0000_BEEF, awready delayed 3 cycles, wready immediate -> wdata=0xBEEF_0000, wstrb=1100, wvalid drops after 1 beat, bready only after both handshakes, wb_rd_wen=0.
- LW addr=0x8000_0001 -> no arvalid, wb_valid next cycle with wb_err=1, wb_rd_wen=0.
- LW with rresp=2'b10 -> wb_err=1, wb_data=0. Hold wb_ready=0 for 4 cycles -> outputs stable and ex_ready=0 throughout.
- Assert rst_n=0 while in R state -> rready, wb_valid and all outputs 0 immediately. After release, ex_ready=1 and a fresh LW completes normally.
